truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 111 +++++++++++
 tb/tb_truth_table_sweeper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every input minterm of an N-input function, samples its output and
// assembles the truth table, its on-set weight and a match against a reference.
module truth_table_sweeper #(
  parameter int N = 7,
  parameter int SETTLE = 0,
  parameter logic [(2**N)-1:0] EXPECTED = 128'hfee8e8e8e8e8e880fee8e8e8e8e8e880
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              f,
  output logic [N-1:0]      x,
  output logic              busy,
  output logic              done,
  output logic [(2**N)-1:0] table_out,
  output logic [N:0]        ones,
  output logic              match
);

  localparam int W  = 2**N;
  localparam int OW = N + 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);
  localparam logic [N-1:0]  X_LAST   = '1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] scnt;
  logic [W-1:0]  table_next;
  logic          sample;

  // The table including the bit sampled this cycle, so match can be judged on
  // the complete table in the same edge that raises done.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    table_next    = table_out;
    table_next[x] = f;
  end

  assign sample = (scnt == SETTLE_C);

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      scnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      ones      <= '0;
      match     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            x         <= '0;
            scnt      <= '0;
            table_out <= '0;
            ones      <= '0;
            match     <= 1'b0;
          end
        end

        SWEEP: begin
          // Abort keeps the partially collected table and weight for inspection.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            x     <= '0;
            scnt  <= '0;
            match <= 1'b0;
          end else if (!sample) begin
            scnt <= scnt + 1'b1;
          end else begin
            table_out <= table_next;
            ones      <= ones + OW'(f);
            scnt      <= '0;
            if (x == X_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              x     <= '0;
              match <= (table_next == EXPECTED);
            end else begin
              x <= x + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a combinational instance (SETTLE=0) and a
// pipelined instance (SETTLE=2), checked against a table-building reference model.
module tb_truth_table_sweeper;

  localparam logic [127:0] REF_EXPECTED = 128'hfee8e8e8e8e8e880fee8e8e8e8e8e880;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort;
  int           sel;
  int           mode;
  logic [127:0] rtab;

  logic         start0, start1, abort0, abort1, f0, f1;
  logic [6:0]   x0, x1;
  logic         busy0, busy1, done0, done1, match0, match1;
  logic [127:0] tab0, tab1;
  logic [7:0]   ones0, ones1;

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign abort0 = abort && (sel == 0);
  assign abort1 = abort && (sel == 1);

  truth_table_sweeper dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .f(f0),
    .x(x0), .busy(busy0), .done(done0), .table_out(tab0), .ones(ones0), .match(match0)
  );

  truth_table_sweeper #(.SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .f(f1),
    .x(x1), .busy(busy1), .done(done1), .table_out(tab1), .ones(ones1), .match(match1)
  );

  // Function-under-evaluation: 0 x0, 1 classification, 2 const 1, 3 const 0,
  // 4 random table, 5 x6.
  function automatic logic model_f(int m, logic [6:0] idx, logic [127:0] rt);
    int lo, thr;
    lo  = int'(idx[0]) + int'(idx[1]) + int'(idx[2]);
    thr = (idx[5:3] == 3'd0) ? 3 : (idx[5:3] == 3'd7) ? 1 : 2;
    case (m)
      0:       return idx[0];
      1:       return (lo >= thr);
      2:       return 1'b1;
      3:       return 1'b0;
      4:       return rt[idx];
      5:       return idx[6];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] build_table(int m, logic [127:0] rt);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 128; i++) t[i] = model_f(m, 7'(i), rt);
    return t;
  endfunction

  assign f0 = model_f(mode, x0, rtab);

  // Two-stage pipelined function for the SETTLE=2 instance.
  logic p1 = 1'b0, p2 = 1'b0;
  always @(posedge clk) begin
    p1 <= model_f(mode, x1, rtab);
    p2 <= p1;
  end
  assign f1 = p2;

  logic [6:0]   xv;
  logic         busyv, donev, matchv;
  logic [127:0] tabv;
  logic [7:0]   onesv;
  assign xv     = (sel == 0) ? x0 : x1;
  assign busyv  = (sel == 0) ? busy0 : busy1;
  assign donev  = (sel == 0) ? done0 : done1;
  assign matchv = (sel == 0) ? match0 : match1;
  assign tabv   = (sel == 0) ? tab0 : tab1;
  assign onesv  = (sel == 0) ? ones0 : ones1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One sweep on the selected instance. abort_at >= 0 aborts while x == abort_at.
  task automatic sweep(input string tag, input int settle, input int abort_at,
                       input bit mid_starts, input bit start_in_done);
    logic [127:0] exp, mask;
    int total, e, done_edge, xbad, nd, xi;
    bit aborted;
    exp       = build_table(mode, rtab);
    total     = 128 * (settle + 1);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check({tag, " busy_on_start"}, 128'(busyv), 128'(1'b1));
    done_edge = -1;
    xbad      = 0;
    aborted   = 1'b0;
    e         = 0;
    while (done_edge < 0 && !aborted && e < total + 16) begin
      xi = e / (settle + 1);
      if (e < total && (xv !== 7'(xi) || busyv !== 1'b1 || donev !== 1'b0)) xbad++;
      start = mid_starts && (e % (settle + 1) == 0) && (xi == 10 || xi == 30);
      abort = (abort_at >= 0) && (e == abort_at * (settle + 1));
      tick();
      e++;
      if (abort) aborted = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      if (donev === 1'b1) done_edge = e;
    end
    check({tag, " x_sequence_errors"}, 128'(xbad), 128'(0));
    if (aborted) begin
      mask = (128'd1 << abort_at) - 128'd1;
      check({tag, " abort_busy"},  128'(busyv), 128'(1'b0));
      check({tag, " abort_x"},     128'(xv), 128'(0));
      check({tag, " abort_done"},  128'(donev), 128'(1'b0));
      check({tag, " abort_match"}, 128'(matchv), 128'(1'b0));
      check({tag, " abort_table"}, tabv, exp & mask);
      check({tag, " abort_ones"},  128'(onesv), 128'($countones(exp & mask)));
      nd = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (donev !== 1'b0 || busyv !== 1'b0) nd++;
      end
      check({tag, " abort_stays_idle"}, 128'(nd), 128'(0));
    end else begin
      check({tag, " done_edge"}, 128'(done_edge), 128'(total));
      check({tag, " done_busy"}, 128'(busyv), 128'(1'b0));
      check({tag, " done_x"},    128'(xv), 128'(0));
      check({tag, " table"},     tabv, exp);
      check({tag, " ones"},      128'(onesv), 128'($countones(exp)));
      check({tag, " match"},     128'(matchv), 128'(exp == REF_EXPECTED));
      start = start_in_done;
      tick();
      start = 1'b0;
      check({tag, " done_pulse_end"}, 128'(donev), 128'(1'b0));
      check({tag, " idle_busy"},      128'(busyv), 128'(1'b0));
      check({tag, " table_hold"},     tabv, exp);
      check({tag, " match_hold"},     128'(matchv), 128'(exp == REF_EXPECTED));
      if (start_in_done) begin
        tick();
        check({tag, " start_in_done_ignored"}, 128'(busyv), 128'(1'b0));
      end
    end
  endtask

  initial begin
    int bad;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sel   = 0;
    mode  = 0;
    rtab  = '0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reset x0",     128'(x0), 128'(0));
    check("reset busy0",  128'(busy0), 128'(1'b0));
    check("reset done0",  128'(done0), 128'(1'b0));
    check("reset table0", tab0, 128'(0));
    check("reset ones0",  128'(ones0), 128'(0));
    check("reset match0", 128'(match0), 128'(1'b0));
    check("reset busy1",  128'(busy1), 128'(1'b0));
    check("reset table1", tab1, 128'(0));
    rst = 1'b0;
    tick();

    mode = 0; sweep("x0", 0, -1, 1'b0, 1'b0);
    mode = 1; sweep("classify", 0, -1, 1'b0, 1'b0);
    mode = 2; sweep("const1", 0, -1, 1'b0, 1'b1);
    mode = 3; sweep("const0", 0, -1, 1'b0, 1'b0);

    sel = 1; mode = 5; sweep("pipe_x6", 2, -1, 1'b0, 1'b0);
    sel = 0;

    mode = 1; sweep("abort40", 0, 40, 1'b1, 1'b0);
    sweep("after_abort", 0, -1, 1'b0, 1'b0);

    mode = 4;
    for (int r = 0; r < 3; r++) begin
      rtab = {$urandom(), $urandom(), $urandom(), $urandom()};
      sweep("random", 0, -1, 1'b1, 1'b0);
    end
    rtab = {$urandom(), $urandom(), $urandom(), $urandom()};
    sweep("random_abort", 0, int'($urandom_range(1, 126)), 1'b1, 1'b0);
    sel = 1;
    rtab = {$urandom(), $urandom(), $urandom(), $urandom()};
    sweep("random_pipe", 2, -1, 1'b0, 1'b0);
    sel = 0;

    // Reset in the same cycle as start, mid-sweep at x=77.
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (77) tick();
    check("pre_reset x", 128'(x0), 128'(77));
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst x",     128'(x0), 128'(0));
    check("rst busy",  128'(busy0), 128'(1'b0));
    check("rst done",  128'(done0), 128'(1'b0));
    check("rst table", tab0, 128'(0));
    check("rst ones",  128'(ones0), 128'(0));
    check("rst match", 128'(match0), 128'(1'b0));
    bad = 0;
    for (int i = 0; i < 140; i++) begin
      tick();
      if (done0 !== 1'b0 || busy0 !== 1'b0 || x0 !== 7'd0) bad++;
    end
    check("rst stays idle", 128'(bad), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
